// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo buffer: data width, default sizing and
// the transmit FSM state encoding.
package uart_pkg;

  localparam int DATA_W              = 8;
  localparam int DEPTH_DEFAULT       = 16;
  localparam int ACK_TIMEOUT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_echo_buffer_if.sv
// Byte link between async_receiver / async_transmitter and the echo buffer.
//   rx_data, rx_ready : received byte and its one-cycle strobe
//   tx_busy           : transmitter busy flag
//   tx_data, tx_start : byte to send and its one-cycle start strobe
// slave  : the echo buffer side
// master : the UART receiver/transmitter side
interface uart_echo_buffer_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic              tx_busy;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;

  modport slave (
    input  rx_data,
    input  rx_ready,
    input  tx_busy,
    output tx_data,
    output tx_start
  );

  modport master (
    output rx_data,
    output rx_ready,
    output tx_busy,
    input  tx_data,
    input  tx_start
  );

endinterface

// File: rtl/uart_fifo.sv
// Byte FIFO with registered occupancy count and status flags.
//   clk, rst_n : clock and asynchronous active-low reset
//   push       : write wr_data at the write pointer (ignored when full without pop)
//   pop        : advance the read pointer (ignored when empty)
//   rd_data    : head byte, valid while empty is low
//   count      : bytes held, 0..DEPTH
//   full/empty : count==DEPTH / count==0
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_r;
  logic              empty_r;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic [CNT_W-1:0]  count_nxt_s;

  // A push into a full FIFO is only legal when a pop frees a slot on the same edge.
  assign pop_ok_s  = pop && !empty_r;
  assign push_ok_s = push && (!full_r || pop_ok_s);

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage is not reset; stale bytes are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, count and flags advance together so the flags never lag count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_W'(DEPTH));
      empty_r <= (count_nxt_s == {CNT_W{1'b0}});
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign full    = full_r;
  assign empty   = empty_r;

endmodule

// File: rtl/uart_echo_buffer.sv
// Echo buffer between async_receiver and async_transmitter: received bytes are
// queued in a FIFO and replayed to the transmitter one at a time.
//   CLOCK_50  : system clock
//   KEY       : asynchronous active-low reset
//   link      : rx_data/rx_ready in, tx_busy in, tx_data/tx_start out
//   clear_ovf : synchronous clear of the sticky overflow flag
//   count     : bytes held in the FIFO
//   full/empty: FIFO status
//   overflow  : set when a byte arrives with the FIFO full and no pop
// After each start pulse the FSM waits up to ACK_TIMEOUT cycles for tx_busy to
// rise; if it never does the byte is treated as sent so the queue cannot stall.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                   CLOCK_50,
  input  logic                   KEY,
  uart_echo_buffer_if.slave      link,
  input  logic                   clear_ovf,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  tx_state_t         state_r;
  logic [TMR_W-1:0]  timer_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              tx_start_r;
  logic              overflow_r;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic [DATA_W-1:0] head_s;

  // Pop only from IDLE so exactly one byte is in flight at a time.
  assign pop_s  = (state_r == IDLE) && !empty && !link.tx_busy;
  assign push_s = link.rx_ready && (!full || pop_s);
  assign drop_s = link.rx_ready && full && !pop_s;

  uart_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (KEY),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (link.rx_data),
    .rd_data (head_s),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Transmit FSM; tx_start is raised on the edge entering START so it is high
  // for exactly the START cycle.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state_r    <= IDLE;
      timer_r    <= {TMR_W{1'b0}};
      tx_data_r  <= 8'h00;
      tx_start_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            tx_data_r  <= head_s;
            tx_start_r <= 1'b1;
            state_r    <= START;
          end else begin
            tx_start_r <= 1'b0;
          end
        end
        START: begin
          tx_start_r <= 1'b0;
          timer_r    <= TMR_W'(ACK_TIMEOUT);
          state_r    <= WAIT_HI;
        end
        WAIT_HI: begin
          tx_start_r <= 1'b0;
          if (link.tx_busy) begin
            state_r <= WAIT_LO;
          end else if (timer_r <= TMR_W'(1)) begin
            // Timer reaches zero on this edge: give up waiting for the ack.
            timer_r <= {TMR_W{1'b0}};
            state_r <= IDLE;
          end else begin
            timer_r <= timer_r - TMR_W'(1);
          end
        end
        WAIT_LO: begin
          tx_start_r <= 1'b0;
          if (!link.tx_busy) begin
            state_r <= IDLE;
          end
        end
        default: begin
          tx_start_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Sticky overflow; a drop on the same edge as clear_ovf wins.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clear_ovf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign link.tx_data  = tx_data_r;
  assign link.tx_start = tx_start_r;
  assign overflow      = overflow_r;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed self-checking bench for uart_echo_buffer (DEPTH=16, ACK_TIMEOUT=4).
// Bytes expected to be transmitted are queued when driven; a monitor pops the
// queue on every tx_start pulse and compares tx_data.
module tb_uart_echo_buffer;
  import uart_pkg::*;

  logic       clk;
  logic       key;
  logic       clear_ovf;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  uart_echo_buffer_if link ();

  uart_echo_buffer #(
    .DEPTH       (16),
    .ACK_TIMEOUT (4)
  ) dut (
    .CLOCK_50  (clk),
    .KEY       (key),
    .link      (link),
    .clear_ovf (clear_ovf),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       prev_start = 1'b0;
  logic [7:0] exp_byte;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one byte for one edge; queue it if it should reach the transmitter.
  task automatic send(input logic [7:0] b, input bit expect_tx);
    link.rx_data  = b;
    link.rx_ready = 1'b1;
    if (expect_tx) exp_q.push_back(b);
    tick();
    link.rx_ready = 1'b0;
  endtask

  // Scoreboard monitor: every start pulse is single-cycle and carries the next expected byte.
  always @(negedge clk) begin
    if (key === 1'b1 && link.tx_start === 1'b1) begin
      check("start_one_cycle", {31'd0, prev_start}, 32'd0);
      check("sb_has_entry", {31'd0, (exp_q.size() > 0)}, 32'd1);
      if (exp_q.size() > 0) begin
        exp_byte = exp_q.pop_front();
        check("tx_order", {24'd0, link.tx_data}, {24'd0, exp_byte});
      end
    end
    prev_start = link.tx_start;
  end

  initial begin
    key           = 1'b0;
    clear_ovf     = 1'b0;
    link.rx_data  = 8'h00;
    link.rx_ready = 1'b0;
    link.tx_busy  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_start", {31'd0, link.tx_start}, 32'd0);
    check("rst_txdata", {24'd0, link.tx_data}, 32'h00);
    key = 1'b1;

    // Single byte: push, pop next edge, start in the following cycle
    send(8'hA5, 1'b1);
    check("single_count1", {27'd0, count}, 32'd1);
    check("single_nempty", {31'd0, empty}, 32'd0);
    tick();
    check("single_pop_count", {27'd0, count}, 32'd0);
    check("single_start", {31'd0, link.tx_start}, 32'd1);
    check("single_data", {24'd0, link.tx_data}, 32'hA5);
    tick();
    check("single_start_low", {31'd0, link.tx_start}, 32'd0);
    link.tx_busy = 1'b1;
    repeat (10) tick();
    check("single_hold", {24'd0, link.tx_data}, 32'hA5);
    link.tx_busy = 1'b0;
    tick();
    check("single_done_count", {27'd0, count}, 32'd0);
    check("single_done_empty", {31'd0, empty}, 32'd1);

    // Burst with transmitter busy: fill the FIFO
    link.tx_busy = 1'b1;
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b1);
    check("burst_count", {27'd0, count}, 32'd16);
    check("burst_full", {31'd0, full}, 32'd1);
    check("burst_nempty", {31'd0, empty}, 32'd0);

    // Overflow: drop, drop coinciding with clear, then clear
    send(8'hFF, 1'b0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", {27'd0, count}, 32'd16);
    clear_ovf = 1'b1;
    send(8'hFE, 1'b0);
    check("ovf_clear_vs_drop", {31'd0, overflow}, 32'd1);
    tick();
    clear_ovf = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    check("ovf_count2", {27'd0, count}, 32'd16);

    // Full FIFO with push coinciding with a pop: byte accepted
    link.tx_busy = 1'b0;
    send(8'h77, 1'b1);
    check("fullpop_count", {27'd0, count}, 32'd16);
    check("fullpop_full", {31'd0, full}, 32'd1);
    check("fullpop_ovf", {31'd0, overflow}, 32'd0);
    check("fullpop_start", {31'd0, link.tx_start}, 32'd1);
    check("fullpop_data", {24'd0, link.tx_data}, 32'h01);

    // Drain: tx_busy never rises, so each byte leaves via the ack timeout
    for (int i = 0; i < 400; i++) begin
      if (empty && exp_q.size() == 0) break;
      tick();
    end
    check("drain_sb_empty", exp_q.size(), 32'd0);
    check("drain_count", {27'd0, count}, 32'd0);
    repeat (8) tick();

    // Timeout timing: next pop exactly one edge after the FSM returns to IDLE
    send(8'h5A, 1'b1);
    send(8'h6B, 1'b1);
    check("to_start", {31'd0, link.tx_start}, 32'd1);
    check("to_data", {24'd0, link.tx_data}, 32'h5A);
    check("to_count", {27'd0, count}, 32'd1);
    for (int k = 2; k <= 6; k++) begin
      tick();
      check("to_wait_start", {31'd0, link.tx_start}, 32'd0);
      check("to_wait_count", {27'd0, count}, 32'd1);
      check("to_wait_hold", {24'd0, link.tx_data}, 32'h5A);
    end
    tick();
    check("to_next_count", {27'd0, count}, 32'd0);
    check("to_next_start", {31'd0, link.tx_start}, 32'd1);
    check("to_next_data", {24'd0, link.tx_data}, 32'h6B);
    repeat (8) tick();

    // Reset during WAIT_LO with 5 bytes buffered
    send(8'h11, 1'b1);
    tick();
    check("rm_start", {31'd0, link.tx_start}, 32'd1);
    link.tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) send(8'(8'h21 + i), 1'b0);
    check("rm_count5", {27'd0, count}, 32'd5);
    key = 1'b0;
    #1;
    check("rm_count0", {27'd0, count}, 32'd0);
    check("rm_empty", {31'd0, empty}, 32'd1);
    check("rm_full", {31'd0, full}, 32'd0);
    check("rm_txstart", {31'd0, link.tx_start}, 32'd0);
    check("rm_txdata", {24'd0, link.tx_data}, 32'h00);
    tick();
    tick();
    key = 1'b1;
    link.tx_busy = 1'b0;
    send(8'h3C, 1'b1);
    check("rm_push_count", {27'd0, count}, 32'd1);
    tick();
    check("rm_pop_start", {31'd0, link.tx_start}, 32'd1);
    check("rm_pop_data", {24'd0, link.tx_data}, 32'h3C);
    repeat (8) tick();
    check("final_sb_empty", exp_q.size(), 32'd0);
    check("final_count", {27'd0, count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
